// File: rtl/tcp_sched_flag_table.sv
// Per-flow rt/ack_pend/data_pend flag table fed by scheduler commands, with a round-robin
// pending-flow scanner and a one-cycle lookup port. Field op encoding: 0=SET, 1=CLEAR, 2/3=NOP.
module tcp_sched_flag_table #(
    parameter  int unsigned FLOWID_W            = 3,
    parameter  int unsigned TIMESTAMP_W         = 64,
    localparam int unsigned SCHED_CMD_STRUCT_W  = FLOWID_W + 3 * (2 + TIMESTAMP_W),
    localparam int unsigned SCHED_DATA_STRUCT_W = FLOWID_W + 3 * (1 + TIMESTAMP_W)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sched_cmd_val,
    input  logic [SCHED_CMD_STRUCT_W-1:0]  sched_cmd,
    output logic                           sched_cmd_rdy,
    output logic                           sched_data_val,
    output logic [SCHED_DATA_STRUCT_W-1:0] sched_data,
    input  logic                           sched_data_rdy,
    input  logic                           rd_req_val,
    input  logic [FLOWID_W-1:0]            rd_req_flowid,
    output logic                           rd_resp_val,
    output logic [SCHED_DATA_STRUCT_W-1:0] rd_resp_data
);

    localparam int unsigned NUM_FLOWS = 2 ** FLOWID_W;
    localparam int unsigned CMD_FLD_W = 2 + TIMESTAMP_W;
    localparam int unsigned DAT_FLD_W = 1 + TIMESTAMP_W;
    localparam int unsigned ENTRY_W   = 3 * DAT_FLD_W;

    typedef enum logic [1:0] {
        FLAG_SET   = 2'd0,
        FLAG_CLEAR = 2'd1,
        FLAG_NOP   = 2'd2
    } flag_op_t;

    typedef enum logic {
        SCAN,
        HOLD
    } state_t;

    state_t state_q, state_d;

    // Field index 2 = rt, 1 = ack_pend, 0 = data_pend (matches struct packing, rt at MSB).
    logic [2:0]             flag_q [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0] ts_q   [NUM_FLOWS][3];

    logic [FLOWID_W-1:0]    scan_ptr;
    logic                   scan_hit;
    logic [ENTRY_W-1:0]     scan_entry;
    logic [ENTRY_W-1:0]     rd_entry;
    logic                   cmd_acc;
    logic [FLOWID_W-1:0]    cmd_flowid;
    logic [1:0]             cmd_op [3];
    logic [TIMESTAMP_W-1:0] cmd_ts [3];
    logic [FLOWID_W-1:0]    held_flowid;

    assign cmd_acc     = sched_cmd_val && sched_cmd_rdy;
    assign cmd_flowid  = sched_cmd[SCHED_CMD_STRUCT_W-1 -: FLOWID_W];
    assign scan_hit    = |flag_q[scan_ptr];
    assign held_flowid = sched_data[SCHED_DATA_STRUCT_W-1 -: FLOWID_W];

    always_comb begin
        scan_entry = '0;
        rd_entry   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            scan_entry[k*DAT_FLD_W +: DAT_FLD_W] = {flag_q[scan_ptr][k], ts_q[scan_ptr][k]};
            rd_entry[k*DAT_FLD_W +: DAT_FLD_W]   = {flag_q[rd_req_flowid][k], ts_q[rd_req_flowid][k]};
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            cmd_op[k] = sched_cmd[k*CMD_FLD_W + TIMESTAMP_W +: 2];
            cmd_ts[k] = sched_cmd[k*CMD_FLD_W +: TIMESTAMP_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_cmd_rdy <= 1'b0;
        end else begin
            sched_cmd_rdy <= 1'b1;
        end
    end

    // Scanner and lookup read the registered table, so a same-cycle command is not visible to them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                flag_q[f] <= '0;
                for (int unsigned k = 0; k < 3; k++) begin
                    ts_q[f][k] <= '0;
                end
            end
        end else if (cmd_acc) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (cmd_op[k] == FLAG_SET) begin
                    flag_q[cmd_flowid][k] <= 1'b1;
                    ts_q[cmd_flowid][k]   <= cmd_ts[k];
                end else if (cmd_op[k] == FLAG_CLEAR) begin
                    flag_q[cmd_flowid][k] <= 1'b0;
                    ts_q[cmd_flowid][k]   <= cmd_ts[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (scan_hit) state_d = HOLD;
            HOLD:    if (sched_data_rdy) state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        sched_data_val = (state_q == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr   <= '0;
            sched_data <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (scan_hit) begin
                        sched_data <= {scan_ptr, scan_entry};
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                HOLD: begin
                    if (sched_data_rdy) begin
                        scan_ptr <= held_flowid + 1'b1;
                    end
                end
                default: scan_ptr <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_resp_val  <= 1'b0;
            rd_resp_data <= '0;
        end else begin
            rd_resp_val <= rd_req_val;
            if (rd_req_val) begin
                rd_resp_data <= {rd_req_flowid, rd_entry};
            end
        end
    end

endmodule

// File: tb/tb_tcp_sched_flag_table.sv
// Bench for tcp_sched_flag_table: directed scenarios plus randomized command/lookup traffic
// checked against an array-based table model and a "next pending flow" fairness model.
module tb_tcp_sched_flag_table;

    localparam int FW = 3;
    localparam int TW = 64;
    localparam int N  = 8;
    localparam int CF = 2 + TW;
    localparam int DF = 1 + TW;
    localparam int CW = FW + 3 * CF;
    localparam int DW = FW + 3 * DF;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_CLR = 2'd1;
    localparam logic [1:0] OP_NOP = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sched_cmd_val;
    logic [CW-1:0] sched_cmd;
    logic          sched_cmd_rdy;
    logic          sched_data_val;
    logic [DW-1:0] sched_data;
    logic          sched_data_rdy;
    logic          rd_req_val;
    logic [FW-1:0] rd_req_flowid;
    logic          rd_resp_val;
    logic [DW-1:0] rd_resp_data;

    int errors = 0;
    int checks = 0;

    logic          mflag [N][3];
    logic [TW-1:0] mts   [N][3];

    tcp_sched_flag_table #(.FLOWID_W(FW), .TIMESTAMP_W(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sched_cmd_val  (sched_cmd_val),
        .sched_cmd      (sched_cmd),
        .sched_cmd_rdy  (sched_cmd_rdy),
        .sched_data_val (sched_data_val),
        .sched_data     (sched_data),
        .sched_data_rdy (sched_data_rdy),
        .rd_req_val     (rd_req_val),
        .rd_req_flowid  (rd_req_flowid),
        .rd_resp_val    (rd_resp_val),
        .rd_resp_data   (rd_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int f = 0; f < N; f++)
            for (int k = 0; k < 3; k++) begin
                mflag[f][k] = 1'b0;
                mts[f][k]   = '0;
            end
    endtask

    function automatic logic [CW-1:0] mk_cmd(input int fid,
                                            input logic [1:0] o_rt, input logic [TW-1:0] t_rt,
                                            input logic [1:0] o_ack, input logic [TW-1:0] t_ack,
                                            input logic [1:0] o_dat, input logic [TW-1:0] t_dat);
        logic [CW-1:0] c;
        logic [FW-1:0] f;
        f = fid[FW-1:0];
        c[CW-1 -: FW]   = f;
        c[2*CF +: CF]   = {o_rt, t_rt};
        c[1*CF +: CF]   = {o_ack, t_ack};
        c[0 +: CF]      = {o_dat, t_dat};
        return c;
    endfunction

    task automatic model_apply(input logic [CW-1:0] c);
        int fid;
        logic [1:0] op;
        fid = int'(c[CW-1 -: FW]);
        for (int k = 0; k < 3; k++) begin
            op = c[k*CF + TW +: 2];
            if (op == OP_SET) begin
                mflag[fid][k] = 1'b1;
                mts[fid][k]   = c[k*CF +: TW];
            end else if (op == OP_CLR) begin
                mflag[fid][k] = 1'b0;
                mts[fid][k]   = c[k*CF +: TW];
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_entry(input int fid);
        logic [DW-1:0] r;
        logic [FW-1:0] f;
        f = fid[FW-1:0];
        r[DW-1 -: FW] = f;
        for (int k = 0; k < 3; k++) r[k*DF +: DF] = {mflag[fid][k], mts[fid][k]};
        return r;
    endfunction

    function automatic int next_pending(input int from);
        int f;
        for (int i = 0; i < N; i++) begin
            f = (from + i) % N;
            if (mflag[f][0] || mflag[f][1] || mflag[f][2]) return f;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic send_cmd(input logic [CW-1:0] c);
        sched_cmd_val = 1'b1;
        sched_cmd     = c;
        step();
        sched_cmd_val = 1'b0;
        model_apply(c);
    endtask

    task automatic lookup(input int fid, input string tag);
        logic [DW-1:0] e;
        rd_req_val    = 1'b1;
        rd_req_flowid = fid[FW-1:0];
        e = exp_entry(fid);
        step();
        rd_req_val = 1'b0;
        chk({tag, "_val"}, rd_resp_val, 1'b1);
        chk({tag, "_data"}, rd_resp_data, e);
    endtask

    task automatic wait_val(input string tag, output bit ok);
        for (int i = 0; i < 64 && !sched_data_val; i++) step();
        ok = sched_data_val;
        if (!ok) chk({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic get_snap(input string tag, output logic [DW-1:0] d, output bit ok);
        wait_val(tag, ok);
        d = sched_data;
        if (ok) begin
            sched_data_rdy = 1'b1;
            step();
            sched_data_rdy = 1'b0;
        end
    endtask

    // Table static: each snapshot must be the next pending flow after the previous one.
    task automatic check_order(input string tag, input int n, inout int last, output bit wrapped);
        logic [DW-1:0] d;
        bit ok;
        int e, got;
        wrapped = 1'b0;
        for (int i = 0; i < n; i++) begin
            get_snap(tag, d, ok);
            if (!ok) return;
            e   = next_pending((last + 1) % N);
            got = int'(d[DW-1 -: FW]);
            chk({tag, "_flow"}, got, e);
            chk({tag, "_entry"}, d, exp_entry(e));
            if (got <= last) wrapped = 1'b1;
            last = got;
        end
    endtask

    initial begin
        logic [DW-1:0] d, held, prev_data;
        bit ok, wrapped, prev_val, prev_rdy, req;
        int last, fid;
        logic [CW-1:0] c;
        logic [DW-1:0] e;
        int bad;

        rst_n = 1'b0; sched_cmd_val = 1'b0; sched_cmd = '0; sched_data_rdy = 1'b0;
        rd_req_val = 1'b0; rd_req_flowid = '0;
        model_reset();
        repeat (3) step();
        chk("reset_cmd_rdy", sched_cmd_rdy, 1'b0);
        chk("reset_data_val", sched_data_val, 1'b0);
        chk("reset_data", sched_data, '0);
        chk("reset_resp_val", rd_resp_val, 1'b0);
        rst_n = 1'b1;
        step();
        chk("cmd_rdy_after_reset", sched_cmd_rdy, 1'b1);

        // Idle: empty table never produces a snapshot.
        bad = 0;
        repeat (20) begin step(); if (sched_data_val !== 1'b0) bad++; end
        chk("idle_no_snapshot", bad, 0);
        for (int f = 0; f < N; f++) lookup(f, "idle_lookup");

        // Single pending flow 5, re-emitted each lap.
        send_cmd(mk_cmd(5, OP_SET, 64'h10, OP_NOP, 64'h0, OP_SET, 64'h20));
        get_snap("t2", d, ok);
        chk("t2_flow", d[DW-1 -: FW], 3'd5);
        chk("t2_rt", d[2*DF +: DF], {1'b1, 64'h10});
        chk("t2_ack", d[1*DF +: DF], {1'b0, 64'h0});
        chk("t2_data", d[0 +: DF], {1'b1, 64'h20});
        chk("t2_val_drop", sched_data_val, 1'b0);
        get_snap("t2b", d, ok);
        chk("t2_repeat", d, exp_entry(5));

        // Flows 1,3,6 pending; first snapshot may be stale, then strict round-robin.
        send_cmd(mk_cmd(5, OP_CLR, 64'h0, OP_CLR, 64'h0, OP_CLR, 64'h0));
        send_cmd(mk_cmd(1, OP_SET, rnd64(), OP_NOP, 64'h0, OP_NOP, 64'h0));
        send_cmd(mk_cmd(3, OP_NOP, 64'h0, OP_SET, rnd64(), OP_NOP, 64'h0));
        send_cmd(mk_cmd(6, OP_NOP, 64'h0, OP_NOP, 64'h0, OP_SET, rnd64()));
        get_snap("t3_drain", d, ok);
        last = int'(d[DW-1 -: FW]);
        check_order("t3", 7, last, wrapped);
        chk("t3_wrap_seen", wrapped, 1'b1);

        // Hold flow 3, clear it underneath: snapshot must stay frozen.
        wait_val("t4", ok);
        for (int i = 0; i < 4 && ok && sched_data[DW-1 -: FW] != 3'd3; i++) begin
            sched_data_rdy = 1'b1; step(); sched_data_rdy = 1'b0;
            wait_val("t4", ok);
        end
        chk("t4_held_flow", sched_data[DW-1 -: FW], 3'd3);
        held = exp_entry(3);
        send_cmd(mk_cmd(3, OP_CLR, 64'h99, OP_CLR, 64'h99, OP_CLR, 64'h99));
        repeat (5) step();
        chk("t4_still_val", sched_data_val, 1'b1);
        chk("t4_snapshot_frozen", sched_data, held);
        sched_data_rdy = 1'b1; step(); sched_data_rdy = 1'b0;
        last = 3;
        check_order("t4", 6, last, wrapped);

        // Same-cycle command and lookup of flow 2: lookup sees old value.
        sched_cmd_val = 1'b1;
        c = mk_cmd(2, OP_SET, 64'h7, OP_NOP, 64'h0, OP_NOP, 64'h0);
        sched_cmd = c;
        rd_req_val = 1'b1; rd_req_flowid = 3'd2;
        e = exp_entry(2);
        step();
        sched_cmd_val = 1'b0; rd_req_val = 1'b0;
        model_apply(c);
        chk("t5_old_rt", rd_resp_data[2*DF +: DF], {1'b0, 64'h0});
        chk("t5_old_entry", rd_resp_data, e);
        lookup(2, "t5_new");
        chk("t5_new_rt", rd_resp_data[2*DF +: DF], {1'b1, 64'h7});
        step();
        chk("t5_resp_val_low", rd_resp_val, 1'b0);
        chk("t5_resp_hold", rd_resp_data, exp_entry(2));

        // Random traffic: lookups against the model, snapshot stability under backpressure.
        for (int cyc = 0; cyc < 300; cyc++) begin
            sched_cmd_val = ($urandom % 2) == 0;
            fid = int'($urandom % N);
            c = mk_cmd(fid, 2'($urandom % 4), rnd64(), 2'($urandom % 4), rnd64(),
                       2'($urandom % 4), rnd64());
            sched_cmd = c;
            req = ($urandom % 2) == 0;
            rd_req_val = req;
            rd_req_flowid = FW'($urandom % N);
            e = exp_entry(int'(rd_req_flowid));
            sched_data_rdy = ($urandom % 3) == 0;
            prev_val = sched_data_val; prev_rdy = sched_data_rdy; prev_data = sched_data;
            step();
            if (sched_cmd_val) model_apply(c);
            chk("rnd_resp_val", rd_resp_val, req);
            if (req) chk("rnd_resp_data", rd_resp_data, e);
            if (prev_val && !prev_rdy) begin
                chk("rnd_hold_val", sched_data_val, 1'b1);
                chk("rnd_hold_data", sched_data, prev_data);
            end else if (prev_val && prev_rdy) begin
                chk("rnd_handshake_drop", sched_data_val, 1'b0);
            end
        end
        sched_cmd_val = 1'b0; rd_req_val = 1'b0; sched_data_rdy = 1'b0;
        step();
        for (int f = 0; f < N; f++) lookup(f, "rnd_table");
        if (next_pending(0) >= 0) begin
            get_snap("rnd_drain", d, ok);
            last = int'(d[DW-1 -: FW]);
            check_order("rnd_order", 2 * N, last, wrapped);
        end else begin
            bad = 0;
            repeat (40) begin step(); if (sched_data_val !== 1'b0) bad++; end
            chk("rnd_empty_no_snapshot", bad, 0);
        end

        // Asynchronous reset while holding a snapshot.
        send_cmd(mk_cmd(6, OP_SET, rnd64(), OP_NOP, 64'h0, OP_NOP, 64'h0));
        wait_val("t6", ok);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_val", sched_data_val, 1'b0);
        chk("t6_async_data", sched_data, '0);
        chk("t6_async_cmd_rdy", sched_cmd_rdy, 1'b0);
        model_reset();
        step();
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin step(); if (sched_data_val !== 1'b0) bad++; end
        chk("t6_no_snapshot_after_reset", bad, 0);
        lookup(6, "t6_lookup_cleared");
        send_cmd(mk_cmd(4, OP_NOP, 64'h0, OP_NOP, 64'h0, OP_SET, 64'hABCD));
        get_snap("t6_new", d, ok);
        chk("t6_new_snapshot", d, exp_entry(4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
